// File: rtl/pwm_peripheral.sv
// 16-output driver: each pin is held low, driven static high, or follows one shared
// 8-bit PWM waveform whose duty is shadowed at the period boundary.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_period_start
);

  // A one-bit prescaler keeps CLK_DIV=1 legal; it then stays at 0 and ticks every clk.
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [7:0]    pwm_cnt;
  logic [7:0]    duty_shadow;
  logic          tick;
  logic          pwm_raw;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic [15:0]   out_next;

  assign tick   = (prescaler == PRE_MAX);
  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Full-scale code is forced high so 0xFF has no one-step dip at count 255.
  assign pwm_raw = (duty_shadow == 8'hFF) ? 1'b1 : (pwm_cnt < duty_shadow);

  always_comb begin
    out_next = '0;
    for (int i = 0; i < 16; i++) begin
      out_next[i] = en_out[i] & (~en_pwm[i] | pwm_raw);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler        <= '0;
      pwm_cnt          <= 8'h00;
      duty_shadow      <= 8'h00;
      out              <= 16'h0000;
      pwm_period_start <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
      end
      // Duty only changes at the wrap so a mid-period write can never produce a runt pulse.
      if (tick && (pwm_cnt == 8'hFF)) begin
        duty_shadow <= pwm_duty_cycle;
      end
      out              <= out_next;
      pwm_period_start <= (pwm_cnt == 8'h00) && (prescaler == '0);
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral (CLK_DIV=13, period 3328 clk); expected values
// are hand-computed from duty*13 and checked with immediate assertions.
module tb_pwm_peripheral;

  localparam int PERIOD = 3328;

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        pwm_period_start;

  int tests_run = 0;
  int tests_failed = 0;

  pwm_peripheral #(.CLK_DIV(13)) dut (
    .clk              (clk),
    .rst              (rst),
    .en_reg_out_7_0   (en_reg_out_7_0),
    .en_reg_out_15_8  (en_reg_out_15_8),
    .en_reg_pwm_7_0   (en_reg_pwm_7_0),
    .en_reg_pwm_15_8  (en_reg_pwm_15_8),
    .pwm_duty_cycle   (pwm_duty_cycle),
    .out              (out),
    .pwm_period_start (pwm_period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
  endtask

  // Advance to the next negedge on which pwm_period_start is high.
  task automatic wait_pps(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pwm_period_start && n < 5000);
    if (!pwm_period_start) check({tag, "_pps_timeout"}, 32'(pwm_period_start), 32'd1);
  endtask

  // Sample one full period starting at the current (pps) negedge; optional mid-period duty write.
  task automatic measure(input int chg_at, input logic [7:0] chg_duty,
                         output int hi, output int bad);
    hi  = 0;
    bad = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i != 0) @(negedge clk);
      if (i == chg_at) pwm_duty_cycle = chg_duty;
      if (out[0]) hi++;
      if (out[15:8] != 8'h00) bad++;
      if (out[7:0] != {8{out[0]}}) bad++;
    end
  endtask

  initial begin
    int n;
    int zero_bad;
    int hi;
    int bad;

    rst = 1'b1;
    set_en(16'h0000, 16'h0000);
    pwm_duty_cycle = 8'h80;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(out), 32'h0);
    check("reset_pps", 32'(pwm_period_start), 32'd0);

    // T1: disabled outputs stay low, period pulses every 3328 clk
    rst = 1'b0;
    @(negedge clk);
    check("t1_first_pps", 32'(pwm_period_start), 32'd1);
    zero_bad = 0;
    for (int p = 0; p < 2; p++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (out != 16'h0000) zero_bad++;
      end while (!pwm_period_start && n < 5000);
      check("t1_period_len", 32'(n), 32'(PERIOD));
    end
    check("t1_out_zero", 32'(zero_bad), 32'd0);

    // T2: static high, single-bit clear, en_pwm without en_out
    set_en(16'hFFFF, 16'h0000);
    @(negedge clk);
    check("t2_all_high", 32'(out), 32'hFFFF);
    set_en(16'hFFF7, 16'h0000);
    @(negedge clk);
    check("t2_clear_bit3", 32'(out), 32'hFFF7);
    set_en(16'h00FF, 16'hFF00);
    @(negedge clk);
    check("t2_pwm_no_en", 32'(out), 32'h00FF);

    // T3: 50% duty on out[7:0]
    set_en(16'h00FF, 16'h00FF);
    wait_pps("t3");
    check("t3_start_high", 32'(out), 32'h00FF);
    measure(-1, 8'h00, hi, bad);
    check("t3_high_time", 32'(hi), 32'd1664);
    check("t3_shape", 32'(bad), 32'd0);
    check("t3_end_low", 32'(out), 32'h0000);

    // T4: duty boundaries
    pwm_duty_cycle = 8'h00;
    wait_pps("t4a");
    wait_pps("t4a");
    measure(-1, 8'h00, hi, bad);
    check("t4_duty00_high", 32'(hi), 32'd0);

    pwm_duty_cycle = 8'hFF;
    wait_pps("t4b");
    wait_pps("t4b");
    measure(-1, 8'h00, hi, bad);
    check("t4_dutyFF_high", 32'(hi), 32'(PERIOD));
    @(negedge clk);
    check("t4_dutyFF_wrap", 32'(out), 32'h00FF);

    pwm_duty_cycle = 8'h01;
    wait_pps("t4c");
    wait_pps("t4c");
    measure(-1, 8'h00, hi, bad);
    check("t4_duty01_high", 32'(hi), 32'd13);
    check("t4_duty01_shape", 32'(bad), 32'd0);

    // T5: mid-period change 0x40 -> 0xC0 only affects the following period
    pwm_duty_cycle = 8'h40;
    wait_pps("t5");
    wait_pps("t5");
    measure(1500, 8'hC0, hi, bad);
    check("t5_old_period", 32'(hi), 32'd832);
    wait_pps("t5");
    measure(-1, 8'h00, hi, bad);
    check("t5_new_period", 32'(hi), 32'd2496);

    // T6: reset in the high phase clears out at once; restart with duty_shadow=0
    wait_pps("t6");
    repeat (100) @(negedge clk);
    check("t6_pre_high", 32'(out), 32'h00FF);
    rst = 1'b1;
    #1;
    check("t6_async_clear", 32'(out), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_restart_pps", 32'(pwm_period_start), 32'd1);
    measure(-1, 8'h00, hi, bad);
    check("t6_first_period", 32'(hi), 32'd0);
    wait_pps("t6");
    measure(-1, 8'h00, hi, bad);
    check("t6_second_period", 32'(hi), 32'd2496);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
